// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD arbiter and its binary-GCD core.
package gcd_pkg;

  // Default operand/result width.
  localparam int unsigned GcdWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StResp
  } state_e;

  // Worst-case number of RUN cycles for a given operand width.
  function automatic int unsigned step_bound(input int unsigned width);
    return 2 * width + 2;
  endfunction

  localparam int unsigned StepBound = step_bound(GcdWidth);

endpackage

// File: rtl/gcd_core.sv
// Binary-GCD (Stein) datapath: one reduction step per clock after i_start.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GcdWidth
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_a, r_b;
  logic [KW-1:0]    r_k;
  logic             r_active;
  logic [WIDTH-1:0] w_a_next, w_b_next;
  logic [KW-1:0]    w_k_next;

  // Zero operands can only appear at load time, so they resolve in the first step with k=0.
  always_comb begin
    o_done   = r_active && ((r_a == '0) || (r_b == '0) || (r_a == r_b));
    o_result = (r_a == '0) ? r_b : ((r_b == '0) ? r_a : (r_a << r_k));
  end

  // One Stein step; the odd/odd case folds the halving of the (even) difference into the same
  // cycle so every step removes at least one operand bit, bounding RUN at 2*WIDTH+2 cycles.
  always_comb begin
    w_a_next = r_a;
    w_b_next = r_b;
    w_k_next = r_k;
    if (!r_a[0] && !r_b[0]) begin
      w_a_next = r_a >> 1;
      w_b_next = r_b >> 1;
      w_k_next = r_k + KW'(1);
    end else if (!r_a[0]) begin
      w_a_next = r_a >> 1;
    end else if (!r_b[0]) begin
      w_b_next = r_b >> 1;
    end else if (r_a > r_b) begin
      w_a_next = (r_a - r_b) >> 1;
    end else begin
      w_b_next = (r_b - r_a) >> 1;
    end
  end

  // Operand registers: load on start, step while active, idle once done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_a      <= i_a;
      r_b      <= i_b;
      r_k      <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (o_done) begin
        r_active <= 1'b0;
      end else begin
        r_a <= w_a_next;
        r_b <= w_b_next;
        r_k <= w_k_next;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Two-requester round-robin front end around a single binary-GCD core.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GcdWidth
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_id,
  output logic             busy,
  output logic [15:0]      jobs_done
);

  state_e           r_state, w_state_next;
  logic             r_last;  // 1: requester 1 was granted most recently
  logic             r_id;
  logic [WIDTH-1:0] r_result;
  logic [15:0]      r_jobs;
  logic             w_start;
  logic [WIDTH-1:0] w_op_a, w_op_b;
  logic             w_core_done;
  logic [WIDTH-1:0] w_core_result;

  // Round-robin grant, only in IDLE and never while reset is asserted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (r_state == StIdle && !wb_rst_i) begin
      req0_ready = req0_valid && (!req1_valid || r_last);
      req1_ready = req1_valid && (!req0_valid || !r_last);
    end
    w_start = req0_ready || req1_ready;
    w_op_a  = req1_ready ? req1_a : req0_a;
    w_op_b  = req1_ready ? req1_b : req0_b;
  end

  gcd_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_start (w_start),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_done  (w_core_done),
    .o_result(w_core_result)
  );

  // Next-state logic for IDLE -> RUN -> RESP -> IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_next = StRun;
      StRun:   if (w_core_done) w_state_next = StResp;
      StResp:  if (rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant pointer, response register and completion counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_result <= '0;
      r_jobs   <= '0;
    end else begin
      if (w_start) begin
        r_last <= req1_ready;
        r_id   <= req1_ready;
      end
      if (r_state == StRun && w_core_done) begin
        r_result <= w_core_result;
      end
      if (r_state == StResp && rsp_ready) begin
        r_jobs <= r_jobs + 16'd1;
      end
    end
  end

  // Registered outputs.
  always_comb begin
    rsp_valid  = (r_state == StResp);
    rsp_result = r_result;
    rsp_id     = r_id;
    busy       = (r_state != StIdle);
    jobs_done  = r_jobs;
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed and table-driven checks for gcd_arbiter against a Euclid reference model.
module tb_gcd_arbiter;
  import gcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_result;
  logic [15:0] jobs_done;

  int total = 0;
  int bad = 0;
  int exp_jobs = 0;

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  gcd_arbiter #(
    .WIDTH(32)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit id, input logic [31:0] a, input logic [31:0] b);
    if (!id) begin
      req0_valid = 1'b1;
      req0_a = a;
      req0_b = b;
    end else begin
      req1_valid = 1'b1;
      req1_a = a;
      req1_b = b;
    end
  endtask

  // Returns one phase after the accepting edge with that requester's valid dropped.
  task automatic wait_accept(input bit id, output bit ok);
    bit r;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      r = id ? req1_ready : req0_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!id) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // lat = number of cycles between the accepting edge and rsp_valid (1 == T+2).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_jobs++;
  endtask

  task automatic run_job(input string name, input bit id, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, output int lat);
    bit ok;
    lat = 0;
    start_job(id, a, b);
    wait_accept(id, ok);
    check({name, "_accept"}, ok, 1);
    if (ok) begin
      wait_rsp(lat);
      check({name, "_valid"}, rsp_valid, 1);
      check({name, "_result"}, rsp_result, exp);
      check({name, "_id"}, rsp_id, id);
      check({name, "_bound"}, (lat <= int'(StepBound)), 1);
      take_rsp();
      check({name, "_jobs"}, jobs_done, 16'(exp_jobs));
    end
  endtask

  initial begin
    int lat;
    bit ok;
    logic [31:0] g, ra, rb;

    vecs[0]  = '{1'b0, 32'd12, 32'd18, 32'd6};
    vecs[1]  = '{1'b1, 32'd48, 32'd180, 32'd12};
    vecs[2]  = '{1'b0, 32'd17, 32'd0, 32'd17};
    vecs[3]  = '{1'b1, 32'd0, 32'd0, 32'd0};
    vecs[4]  = '{1'b0, 32'd1, 32'd1, 32'd1};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6]  = '{1'b0, 32'h80000000, 32'h40000000, 32'h40000000};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'd1, 32'd1};
    vecs[8]  = '{1'b0, 32'd1024, 32'd96, 32'd32};
    vecs[9]  = '{1'b1, 32'd270, 32'd192, 32'd6};
    vecs[10] = '{1'b0, 32'd7, 32'd13, 32'd1};

    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req1_a = '0;
    req1_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();

    // Reset state, with requests pending to show reset wins over a handshake.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    tick();
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_result", rsp_result, 0);
    check("rst_id", rsp_id, 0);
    check("rst_jobs", jobs_done, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    run_job("basic", 1'b0, 32'd10312050, 32'd29460792, 32'd138, lat);

    foreach (vecs[i]) begin
      run_job($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, lat);
    end

    // Zero-operand latency: accept at T, rsp_valid at T+2.
    run_job("zero_b", 1'b0, 32'd0, 32'd992211318, 32'd992211318, lat);
    check("zero_b_lat", lat, 1);
    run_job("zero_zero", 1'b1, 32'd0, 32'd0, 32'd0, lat);
    check("zero_zero_lat", lat, 1);

    // Tie: req0 wins first, req1 follows; operands changed after acceptance are ignored.
    start_job(1'b0, 32'd1993627629, 32'd1177417612);
    start_job(1'b1, 32'd2097015289, 32'd3812041926);
    #1;
    check("tie1_ready0", req0_ready, 1);
    check("tie1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req0_a = 32'd0;
    req0_b = 32'd0;
    check("tie1_run_busy", busy, 1);
    check("tie1_run_ready1", req1_ready, 0);
    wait_rsp(lat);
    check("tie1_result", rsp_result, 7);
    check("tie1_id", rsp_id, 0);
    take_rsp();
    wait_accept(1'b1, ok);
    check("tie2_accept", ok, 1);
    wait_rsp(lat);
    check("tie2_result", rsp_result, 1);
    check("tie2_id", rsp_id, 1);
    take_rsp();
    start_job(1'b0, 32'd12, 32'd18);
    start_job(1'b1, 32'd5, 32'd10);
    #1;
    check("tie3_ready0", req0_ready, 1);
    check("tie3_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    wait_rsp(lat);
    check("tie3_result", rsp_result, 6);
    check("tie3_id", rsp_id, 0);
    take_rsp();
    wait_accept(1'b1, ok);
    wait_rsp(lat);
    check("tie4_result", rsp_result, 5);
    check("tie4_id", rsp_id, 1);
    take_rsp();
    check("tie_jobs", jobs_done, 16'(exp_jobs));

    // Consumer stall in RESP: outputs hold, nothing new accepted.
    start_job(1'b0, 32'd1924134885, 32'd3151131255);
    wait_accept(1'b0, ok);
    wait_rsp(lat);
    start_job(1'b0, 32'd3, 32'd9);
    start_job(1'b1, 32'd4, 32'd8);
    for (int i = 0; i < 20; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_result", rsp_result, 135);
      check("stall_ready0", req0_ready, 0);
      check("stall_ready1", req1_ready, 0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    take_rsp();
    check("stall_jobs", jobs_done, 16'(exp_jobs));

    // Reset mid-RUN discards the job.
    start_job(1'b0, 32'd992211318, 32'd512609597);
    wait_accept(1'b0, ok);
    repeat (5) tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_jobs = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_jobs", jobs_done, 0);
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_no_rsp", rsp_valid, 0);
      tick();
    end
    run_job("rerun", 1'b0, 32'd992211318, 32'd512609597,
            ref_gcd(32'd992211318, 32'd512609597), lat);

    // Randomised jobs with shared factors against the reference model.
    for (int i = 0; i < 300; i++) begin
      g = $urandom_range(1, 1000);
      ra = g * $urandom_range(0, 4000000);
      rb = g * $urandom_range(0, 4000000);
      if (i % 5 == 0) rb = $urandom;
      run_job("rand", i[0], ra, rb, ref_gcd(ra, rb), lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
